// File: rtl/axi_wr_arbiter_pkg.sv
// axi_wr_arbiter_pkg: bus widths (pkg.vh macro defaults) and AXI constants.
// Override ADDR_WIDTH / AXI_DATA_WIDTH / AXI_ID_WIDTH on the command line.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package axi_wr_arbiter_pkg;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `AXI_DATA_WIDTH;
  localparam int ID_W   = `AXI_ID_WIDTH;
  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] AXSIZE     = 3'($clog2(STRB_W));
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
endpackage

// File: rtl/axi_wr_if.sv
// axi_wr_if: AXI write-channel bundle (AW, W, B).
// master = arbiter side, slave = memory side.
interface axi_wr_if;
  import axi_wr_arbiter_pkg::*;

  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_wr_arbiter_rr.sv
// rr_arbiter: round-robin pick starting one past the last grant.
// Returns a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  int            cand;
  logic [IW-1:0] cidx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last_i) + k) % N;
      cidx = IW'(cand);
      if (!found && req_i[cidx]) begin
        found       = 1'b1;
        idx_o       = cidx;
        gnt_o[cidx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: N:1 round-robin arbiter onto one AXI write master.
// Define AXI_WR_ARB_TIMEOUT_EN to enable the B-channel watchdog.
module axi_wr_arbiter
  import axi_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]      req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        req_wvalid,
  output logic [NUM_REQ-1:0]        req_wready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [NUM_REQ-1:0]        req_err,
  axi_wr_if.master                  axi
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE, S_ADDR, S_DATA, S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      gnt_q, gnt_d;
  logic [IW-1:0]      last_q, last_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_q, beat_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IW-1:0]      arb_idx;
  logic               w_hs, last_beat, tmo;

  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [7:0]         len_a   [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign len_a[i]   = req_len[i*8 +: 8];
    assign wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (arb_oh),
    .idx_o  (arb_idx)
  );

  assign last_beat = (beat_q == len_q);
  assign w_hs      = (state_q == S_DATA) && req_wvalid[gnt_q]
                     && axi.WREADY;

`ifdef AXI_WR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmr_q;
  logic          unused;

  assign tmo = (state_q == S_RESP) && !axi.BVALID
               && (tmr_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || state_q != S_RESP) tmr_q <= '0;
    else                             tmr_q <= tmr_q + TW'(1);
  end

  assign unused = ^axi.BID;
`else
  logic unused;
  assign tmo    = 1'b0;
  assign unused = (^axi.BID) ^ (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    done_d  = '0;
    err_d   = '0;
    unique case (state_q)
      S_IDLE: if (|req_valid) begin
        gnt_d   = arb_idx;
        addr_d  = addr_a[arb_idx];
        len_d   = len_a[arb_idx];
        state_d = S_ADDR;
      end
      S_ADDR: if (axi.AWREADY) begin
        beat_d  = '0;
        state_d = S_DATA;
      end
      S_DATA: if (w_hs) begin
        beat_d = beat_q + 8'd1;
        if (last_beat) state_d = S_RESP;
      end
      S_RESP: if (axi.BVALID || tmo) begin
        // a watchdog expiry is reported as an error completion
        done_d[gnt_q] = 1'b1;
        err_d[gnt_q]  = axi.BVALID ? (axi.BRESP != RESP_OKAY) : 1'b1;
        last_d        = gnt_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    axi.AWID    = ID_W'(gnt_q);
    axi.AWADDR  = addr_q;
    axi.AWLEN   = len_q;
    axi.AWSIZE  = AXSIZE;
    axi.AWBURST = BURST_INCR;
    axi.AWVALID = (state_q == S_ADDR);
    axi.WDATA   = wdata_a[gnt_q];
    axi.WSTRB   = '1;
    axi.WLAST   = (state_q == S_DATA) && last_beat;
    axi.WVALID  = (state_q == S_DATA) && req_wvalid[gnt_q];
    axi.BREADY  = (state_q == S_RESP);
    req_ready   = '0;
    req_wready  = '0;
    if (state_q == S_IDLE && rst_n) req_ready = arb_oh;
    if (state_q == S_DATA) req_wready[gnt_q] = axi.WREADY;
    req_done    = done_q;
    req_err     = err_q;
  end
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// tb_axi_wr_arbiter: scoreboard bench; AXI slave modelled by tasks.
// Watchdog scenario built only with AXI_WR_ARB_TIMEOUT_EN.
module tb_axi_wr_arbiter;
  import axi_wr_arbiter_pkg::*;

  localparam int NR  = 4;
  localparam int TMO = 15;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NR-1:0]        req_valid, req_wvalid;
  logic [NR*ADDR_W-1:0] req_addr;
  logic [NR*8-1:0]      req_len;
  logic [NR*DATA_W-1:0] req_wdata;
  logic [NR-1:0]        req_ready, req_wready, req_done, req_err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb_q[$];
  logic [2*NR-1:0]   rsp_q[$];

  axi_wr_if axi_if();

  axi_wr_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wdata  (req_wdata),
    .req_wvalid (req_wvalid),
    .req_wready (req_wready),
    .req_done   (req_done),
    .req_err    (req_err),
    .axi        (axi_if)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] addr_of(input int g);
    return ADDR_W'(32'h4000_0040 + g * 32'h1000);
  endfunction

  function automatic logic [DATA_W-1:0] beat_data(input int g, input int b);
    return DATA_W'(32'hC0DE_0001 + g * 256 + b * 17);
  endfunction

  function automatic logic [NR-1:0] oh(input int g);
    logic [NR-1:0] v;
    v    = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic setup_req(input int g, input int len);
    req_addr[g*ADDR_W +: ADDR_W] = addr_of(g);
    req_len[g*8 +: 8]            = 8'(len);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at negedge+1 with requests already driven; returns at
  // negedge+1 of the cycle where req_done pulses.
  task automatic do_burst(input int g, input int len,
                          input logic [1:0] bresp,
                          input bit toggle, input bit drop);
    int                cyc;
    int                beat;
    logic [NR-1:0]     want;
    logic [DATA_W-1:0] exp_d;
    logic [2*NR-1:0]   exp_r;
    want = oh(g);
    cyc  = 0;
    while (req_ready === '0 && cyc < 16) begin
      @(negedge clk); #1;
      cyc++;
    end
    checks++;
    if (req_ready !== want) begin
      errors++;
      $display("FAIL grant: req_ready=%b want %b", req_ready, want);
    end
    for (int b = 0; b <= len; b++) sb_q.push_back(beat_data(g, b));

    @(negedge clk);
    axi_if.AWREADY = 1'b1;
    if (drop) req_valid[g] = 1'b0;
    #1;
    checks++;
    if (axi_if.AWVALID !== 1'b1 || axi_if.AWADDR !== addr_of(g) ||
        axi_if.AWLEN !== 8'(len) || axi_if.AWID !== ID_W'(g)) begin
      errors++;
      $display("FAIL aw: v=%b addr=%h len=%0d id=%0d want addr=%h len=%0d id=%0d",
               axi_if.AWVALID, axi_if.AWADDR, axi_if.AWLEN, axi_if.AWID,
               addr_of(g), len, g);
    end
    checks++;
    if (axi_if.AWSIZE !== 3'($clog2(DATA_W / 8)) ||
        axi_if.AWBURST !== 2'b01 || axi_if.WSTRB !== {STRB_W{1'b1}}) begin
      errors++;
      $display("FAIL aw_const: size=%0d burst=%b strb=%h want %0d 01 all-ones",
               axi_if.AWSIZE, axi_if.AWBURST, axi_if.WSTRB,
               $clog2(DATA_W / 8));
    end

    beat = 0;
    cyc  = 0;
    while (beat <= len && cyc < 64) begin
      @(negedge clk);
      axi_if.WREADY = toggle ? (cyc % 2 == 0) : 1'b1;
      req_wvalid[g] = 1'b1;
      req_wdata[g*DATA_W +: DATA_W] = beat_data(g, beat);
      #1;
      if (axi_if.WVALID === 1'b1 && axi_if.WREADY === 1'b1) begin
        exp_d = sb_q.pop_front();
        checks++;
        if (axi_if.WDATA !== exp_d || axi_if.WLAST !== (beat == len) ||
            req_wready !== want) begin
          errors++;
          $display("FAIL wbeat%0d: data=%h last=%b wready=%b want %h %b %b",
                   beat, axi_if.WDATA, axi_if.WLAST, req_wready,
                   exp_d, (beat == len), want);
        end
        beat++;
      end else if (axi_if.WREADY === 1'b0) begin
        checks++;
        if (req_wready !== '0) begin
          errors++;
          $display("FAIL wstall: req_wready=%b want 0", req_wready);
        end
      end
      cyc++;
    end
    checks++;
    if (beat != len + 1) begin
      errors++;
      $display("FAIL beats: got %0d want %0d", beat, len + 1);
    end

    @(negedge clk);
    axi_if.WREADY = 1'b0;
    #1;
    checks++;
    if (axi_if.BREADY !== 1'b1 || axi_if.WVALID !== 1'b0) begin
      errors++;
      $display("FAIL resp_phase: bready=%b wvalid=%b want 1 0",
               axi_if.BREADY, axi_if.WVALID);
    end
    req_wvalid    = '0;
    axi_if.BVALID = 1'b1;
    axi_if.BRESP  = bresp;
    axi_if.BID    = ID_W'($urandom);
    rsp_q.push_back({(bresp != 2'b00) ? want : {NR{1'b0}}, want});

    @(negedge clk);
    axi_if.BVALID = 1'b0;
    axi_if.BRESP  = 2'b00;
    #1;
    exp_r = rsp_q.pop_front();
    checks++;
    if ({req_err, req_done} !== exp_r || axi_if.BREADY !== 1'b0) begin
      errors++;
      $display("FAIL done: err=%b done=%b bready=%b want err=%b done=%b",
               req_err, req_done, axi_if.BREADY,
               exp_r[2*NR-1:NR], exp_r[NR-1:0]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({req_ready, req_wready, req_done, req_err} !== '0) begin
      errors++;
      $display("FAIL rst_req: rdy=%b wrdy=%b done=%b err=%b want 0",
               req_ready, req_wready, req_done, req_err);
    end
    checks++;
    if (axi_if.AWVALID !== 1'b0 || axi_if.WVALID !== 1'b0 ||
        axi_if.BREADY !== 1'b0) begin
      errors++;
      $display("FAIL rst_axi: awv=%b wv=%b br=%b want 0 0 0",
               axi_if.AWVALID, axi_if.WVALID, axi_if.BREADY);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (axi_if.AWVALID !== 1'b0 || axi_if.BREADY !== 1'b0 ||
        req_ready !== '0) begin
      errors++;
      $display("FAIL idle: awv=%b br=%b rdy=%b want 0 0 0",
               axi_if.AWVALID, axi_if.BREADY, req_ready);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    setup_req(0, 3);
    req_valid = 4'b0001;
    #1;
    do_burst(0, 3, 2'b00, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (req_done !== '0 || axi_if.AWVALID !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b awv=%b want 0 0",
               req_done, axi_if.AWVALID);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    @(negedge clk);
    for (int g = 0; g < NR; g++) setup_req(g, g);
    req_valid = '1;
    #1;
    for (int g = 0; g < NR; g++)
      do_burst(g, g, (g == NR - 1) ? 2'b01 : 2'b00, 1'b0, 1'b0);
    req_valid = '0;
  endtask

  task automatic test_len0_err();
    @(negedge clk);
    setup_req(2, 0);
    req_valid = 4'b0100;
    #1;
    do_burst(2, 0, 2'b10, 1'b0, 1'b1);
  endtask

  task automatic test_wready_toggle();
    @(negedge clk);
    setup_req(1, 1);
    req_valid = 4'b0010;
    #1;
    do_burst(1, 1, 2'b00, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    setup_req(3, 3);
    req_valid      = 4'b1000;
    axi_if.AWREADY = 1'b1;
    axi_if.WREADY  = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL mid_grant: req_ready=%b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    req_wvalid[3] = 1'b1;
    req_wdata[3*DATA_W +: DATA_W] = beat_data(3, 0);
    #1;
    checks++;
    if (axi_if.WVALID !== 1'b1 || axi_if.WLAST !== 1'b0) begin
      errors++;
      $display("FAIL mid_beat1: wv=%b wl=%b want 1 0",
               axi_if.WVALID, axi_if.WLAST);
    end
    @(negedge clk);
    req_wdata[3*DATA_W +: DATA_W] = beat_data(3, 1);
    #1;
    checks++;
    if (axi_if.WDATA !== beat_data(3, 1) || axi_if.WVALID !== 1'b1) begin
      errors++;
      $display("FAIL mid_beat2: data=%h wv=%b want %h 1",
               axi_if.WDATA, axi_if.WVALID, beat_data(3, 1));
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (axi_if.WVALID !== 1'b0 || axi_if.AWVALID !== 1'b0 ||
        axi_if.BREADY !== 1'b0 || req_wready !== '0) begin
      errors++;
      $display("FAIL mid_rst: wv=%b awv=%b br=%b wrdy=%b want 0",
               axi_if.WVALID, axi_if.AWVALID, axi_if.BREADY, req_wready);
    end
    rst_n      = 1'b1;
    req_wvalid = '0;
    @(negedge clk);
    setup_req(0, 0);
    setup_req(3, 0);
    req_valid = 4'b1001;
    #1;
    do_burst(0, 0, 2'b00, 1'b0, 1'b1);
    req_valid = '0;
  endtask

`ifdef AXI_WR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    @(negedge clk);
    setup_req(2, 0);
    req_valid      = 4'b0100;
    axi_if.AWREADY = 1'b1;
    axi_if.WREADY  = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL tmo_grant: req_ready=%b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    req_wvalid[2] = 1'b1;
    req_wdata[2*DATA_W +: DATA_W] = beat_data(2, 0);
    #1;
    checks++;
    if (axi_if.WVALID !== 1'b1 || axi_if.WLAST !== 1'b1) begin
      errors++;
      $display("FAIL tmo_beat: wv=%b wl=%b want 1 1",
               axi_if.WVALID, axi_if.WLAST);
    end
    @(negedge clk);
    req_wvalid = '0;
    #1;
    k = 0;
    while (req_err === '0 && k < 40) begin
      @(negedge clk); #1;
      k++;
    end
    checks++;
    if (k != TMO || req_done !== 4'b0100 || req_err !== 4'b0100) begin
      errors++;
      $display("FAIL tmo: cycles=%0d done=%b err=%b want %0d 0100 0100",
               k, req_done, req_err, TMO);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_err !== '0 || axi_if.BREADY !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle: err=%b br=%b want 0 0",
               req_err, axi_if.BREADY);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    req_valid      = '0;
    req_wvalid     = '0;
    req_addr       = '0;
    req_len        = '0;
    req_wdata      = '0;
    axi_if.AWREADY = 1'b0;
    axi_if.WREADY  = 1'b0;
    axi_if.BVALID  = 1'b0;
    axi_if.BRESP   = 2'b00;
    axi_if.BID     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_len0_err();
    test_wready_toggle();
    test_reset_mid();
`ifdef AXI_WR_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axi_wr_arbiter.md
AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023: write-response watchdog limit in cycles.
REQ-003 SHALL have port clk  in  1: the single clock. Reset is synchronous and active-low.
REQ-004 SHALL have port rst_n  in  1: synchronous active-low reset.
REQ-005 SHALL have port req_valid  in  NUM_REQ: burst request per requester.
REQ-006 SHALL have port req_ready  out  NUM_REQ: one-cycle accept pulse.
REQ-007 SHALL have port req_addr  in  NUM_REQ*`ADDR_WIDTH: packed burst start addresses.
REQ-008 SHALL have port req_len  in  NUM_REQ*8: packed AXI lengths, beats-1.
REQ-009 SHALL have port req_wdata  in  NUM_REQ*`AXI_DATA_WIDTH: packed write data.
REQ-010 SHALL have port req_wvalid  in  NUM_REQ: write data valid.
REQ-011 SHALL have port req_wready  out  NUM_REQ: write data accepted.
REQ-012 SHALL have port req_done  out  NUM_REQ: one-cycle burst-complete pulse.
REQ-013 SHALL have port req_err  out  NUM_REQ: one-cycle error pulse, coincident with req_done.
REQ-014 SHALL have AXI write-master ports AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID (out) and AXI_AWREADY (in), widths per pkg.vh.
REQ-015 SHALL have ports AXI_WDATA/WSTRB/WLAST/WVALID (out) and AXI_WREADY (in).
REQ-016 SHALL have ports AXI_BID/BRESP/BVALID (in) and AXI_BREADY (out).

Function
REQ-017 SHALL tie AWSIZE to $clog2(`AXI_DATA_WIDTH/8), AWBURST to 2'b01 (INCR), and WSTRB to all ones.
REQ-018 SHALL implement FSM IDLE->ADDR->DATA->RESP->IDLE.
REQ-019 In IDLE with any req_valid, SHALL grant round-robin starting at last_grant+1, register addr/len/index, pulse req_ready[g] that cycle, and go to ADDR.
REQ-020 In ADDR, SHALL hold registered AWVALID=1, AWADDR, AWLEN, and AWID = grant index zero-extended; on AWREADY, go to DATA with beat_cnt=0.
REQ-021 In DATA, SHALL pass through combinationally: AXI_WVALID=req_wvalid[g], AXI_WDATA=slice g, req_wready[g]=AXI_WREADY, AXI_WLAST=(beat_cnt==len).
REQ-022 In DATA, SHALL increment beat_cnt on each handshake and go to RESP on the handshake with WLAST.
REQ-023 In RESP, SHALL drive BREADY=1; on BVALID, pulse req_done[g] and set req_err[g]=(BRESP!=2'b00), update last_grant=g, and go to IDLE.
REQ-024 Non-granted requesters SHALL see req_ready, req_wready, req_done and req_err all 0.
REQ-025 With no req_valid in IDLE, SHALL stay in IDLE with AWVALID=WVALID=BREADY=0.
REQ-026 req_len=0 SHALL produce a single beat with WLAST on the first beat.
REQ-027 Dropping req_valid after grant SHALL not affect the burst in flight.
REQ-028 BID SHALL be ignored.
REQ-029 Minimum latency: AWVALID rises in the cycle after the req_ready pulse.

Reset
REQ-030 rst_n low SHALL, at the next clk edge, force IDLE, beat_cnt=0, last_grant=NUM_REQ-1 (requester 0 first), and deassert all AXI valid/ready and req_* outputs; this includes reset mid-burst.

Configuration
REQ-031 With AXI_WR_ARB_TIMEOUT_EN defined, a counter in RESP SHALL, after TIMEOUT_CYC cycles without BVALID, pulse req_done[g] and req_err[g] and return to IDLE.
REQ-032 Without AXI_WR_ARB_TIMEOUT_EN, RESP SHALL wait indefinitely, and TIMEOUT_CYC SHALL be unused.

Structure
REQ-033 `ADDR_WIDTH, `AXI_DATA_WIDTH and `AXI_ID_WIDTH SHALL come from pkg.vh; state encoding SHALL be local to the module.
REQ-034 Grant selection SHALL live in sub-module rr_arbiter (inputs: request vector and last_grant; outputs: one-hot grant and index).

Verification
REQ-035 req_valid=4'b0001, len=3, AWREADY=1, WREADY=1 -> AWADDR=req_addr[0], 4 beats, WLAST on beat 4, req_done[0] one cycle after BVALID.
REQ-036 req_valid=4'b1111 held across 4 bursts after reset -> grant order 0,1,2,3.
REQ-037 len=0, BRESP=2'b10 -> single beat with WLAST, req_done[2] and req_err[2] both pulsed.
REQ-038 WREADY toggling 1,0,1,0 with len=1 -> exactly 2 beats transferred, no duplicated data.
REQ-039 rst_n low during DATA beat 2 -> next cycle IDLE, WVALID=0; a new request then grants requester 0.
REQ-040 AXI_WR_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=15, BVALID never asserted -> req_err[g] pulse 15 cycles after entering RESP, then IDLE.
